// File: rtl/quadrilatero_pkg.sv
// Shared types for the quadrilatero matrix unit: operand datatypes and
// the state encoding of the floating-point MAC sequencer.
package quadrilatero_pkg;

  typedef enum logic [1:0] {
    SIZE_32 = 2'b00,
    SIZE_16 = 2'b01,
    SIZE_8  = 2'b10
  } datatype_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } mac_seq_state_t;

endpackage

// File: rtl/quadrilatero_mac_float_seq.sv
// Sequencer in front of the floating-point MAC: streams K operand pairs,
// feeds each MAC result back as the next accumulator, returns the final sum.
module quadrilatero_mac_float_seq
  import quadrilatero_pkg::*;
#(
  parameter int unsigned MAX_K = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_valid_i,
  output logic                         start_ready_o,
  input  logic [$clog2(MAX_K+1)-1:0]   k_i,
  input  datatype_t                    datatype_i,
  input  logic [31:0]                  acc_init_i,
  input  logic                         op_valid_i,
  output logic                         op_ready_o,
  input  logic [31:0]                  data_i,
  input  logic [31:0]                  weight_i,
  output logic [31:0]                  mac_data_o,
  output logic [31:0]                  mac_weight_o,
  output logic [31:0]                  mac_acc_o,
  output datatype_t                    mac_datatype_o,
  output logic                         mac_valid_o,
  input  logic                         mac_finished_i,
  input  logic [31:0]                  mac_acc_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [31:0]                  res_o
);

  localparam int unsigned CNT_W = $clog2(MAX_K + 1);

  mac_seq_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  datatype_t        dtype_q, dtype_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      weight_q, weight_d;
  // High only during the first WAIT cycle, giving a single-cycle issue pulse.
  logic             issue_q, issue_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dtype_q  <= SIZE_32;
      acc_q    <= '0;
      data_q   <= '0;
      weight_q <= '0;
      issue_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dtype_q  <= dtype_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      weight_q <= weight_d;
      issue_q  <= issue_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dtype_d       = dtype_q;
    acc_d         = acc_q;
    data_d        = data_q;
    weight_d      = weight_q;
    issue_d       = 1'b0;
    start_ready_o = 1'b0;
    op_ready_o    = 1'b0;
    mac_valid_o   = 1'b0;
    res_valid_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        start_ready_o = 1'b1;
        if (start_valid_i) begin
          cnt_d   = k_i;
          dtype_d = datatype_i;
          acc_d   = acc_init_i;
          state_d = (k_i == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        op_ready_o = 1'b1;
        if (op_valid_i) begin
          data_d   = data_i;
          weight_d = weight_i;
          issue_d  = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        mac_valid_o = issue_q;
        // Finished may coincide with the issue pulse for a zero-latency MAC.
        if (mac_finished_i) begin
          acc_d   = mac_acc_i;
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? DONE : ISSUE;
        end
      end
      DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mac_data_o     = data_q;
  assign mac_weight_o   = weight_q;
  assign mac_acc_o      = acc_q;
  assign mac_datatype_o = dtype_q;
  assign res_o          = acc_q;

endmodule
